// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffers bytes from the UART receiver in a small FIFO and
// feeds them one at a time to the UART transmitter. Each byte gets a single
// start strobe, then the block waits for the transmitter's done pulse.
// Overflow and fill level are exported for status LEDs.
module uart_echo_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done,
  input  logic        i_ovf_clr,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  output logic [AW:0] o_count,
  output logic        o_empty,
  output logic        o_full,
  output logic        o_overflow
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_s;
  logic          empty_r;
  logic          full_r;
  logic          ovf_r;
  logic          tx_dv_r;
  logic [7:0]    tx_byte_r;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  // Transmit sequencer: issue from IDLE, wait for done, then one gap cycle.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_r && !i_Tx_Active) begin
          pop_s   = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_Tx_Done) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Push/drop decision and next occupancy; a pop frees a slot in the same cycle.
  always_comb begin
    push_s  = 1'b0;
    drop_s  = 1'b0;
    count_s = count_r;
    if (i_Rx_DV) begin
      if (!full_r || pop_s) begin
        push_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // Byte storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_Rx_Byte;
    end
  end

  // Control state, pointers, occupancy flags, sticky overflow and tx outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      wr_ptr_r  <= PTR_ZERO;
      rd_ptr_r  <= PTR_ZERO;
      count_r   <= CNT_ZERO;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      ovf_r     <= 1'b0;
      tx_dv_r   <= 1'b0;
      tx_byte_r <= 8'h00;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      empty_r <= (count_s == CNT_ZERO);
      full_r  <= (count_s == CNT_FULL);
      tx_dv_r <= pop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        tx_byte_r <= mem_r[rd_ptr_r];
      end
      // A fresh drop beats a clear request in the same cycle.
      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (i_ovf_clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign o_Tx_DV    = tx_dv_r;
  assign o_Tx_Byte  = tx_byte_r;
  assign o_count    = count_r;
  assign o_empty    = empty_r;
  assign o_full     = full_r;
  assign o_overflow = ovf_r;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed scenarios plus randomized traffic against a
// queue-based reference model, with a transmitter model answering strobes.
module tb_uart_echo_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk_tb = 1'b0;
  logic        reset;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        i_Tx_Active;
  logic        i_Tx_Done;
  logic        i_ovf_clr;
  logic        o_Tx_DV;
  logic [7:0]  o_Tx_Byte;
  logic [AW:0] o_count;
  logic        o_empty;
  logic        o_full;
  logic        o_overflow;

  uart_echo_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk_tb),
    .reset      (reset),
    .i_Rx_DV    (i_Rx_DV),
    .i_Rx_Byte  (i_Rx_Byte),
    .i_Tx_Active(i_Tx_Active),
    .i_Tx_Done  (i_Tx_Done),
    .i_ovf_clr  (i_ovf_clr),
    .o_Tx_DV    (o_Tx_DV),
    .o_Tx_Byte  (o_Tx_Byte),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  // Free-running clock, 10 ns period.
  always #5 clk_tb = ~clk_tb;

  int passed = 0;
  int total  = 0;

  // Reference model: queue of buffered bytes plus transmit bookkeeping.
  logic [7:0] m_q [$];
  logic       m_ovf;
  logic       m_dv;
  logic [7:0] m_byte;
  logic       m_inflight;
  int         m_block;

  // Transmitter model and observation.
  logic       tx_act;
  int         tx_cnt;
  int         tx_lat;
  logic       hold_busy;
  logic [7:0] seen [$];
  logic [7:0] exp_q [$];
  int         max_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf      = 1'b0;
    m_dv       = 1'b0;
    m_byte     = 8'h00;
    m_inflight = 1'b0;
    m_block    = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic issue;
    logic was_full;
    logic drop;
    issue = 1'b0;
    drop  = 1'b0;
    if (!reset) begin
      model_reset();
    end else begin
      if (m_inflight) begin
        if (i_Tx_Done) begin
          m_inflight = 1'b0;
          m_block    = 1;
        end
      end else if (m_block > 0) begin
        m_block--;
      end else if (m_q.size() > 0 && !i_Tx_Active) begin
        issue = 1'b1;
      end
      was_full = (m_q.size() == DEPTH);
      if (issue) begin
        m_byte     = m_q.pop_front();
        m_inflight = 1'b1;
      end
      m_dv = issue;
      if (i_Rx_DV) begin
        if (!was_full || issue) m_q.push_back(i_Rx_Byte);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (i_ovf_clr) m_ovf = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("count",    o_count,    m_q.size());
    check("empty",    o_empty,    (m_q.size() == 0));
    check("full",     o_full,     (m_q.size() == DEPTH));
    check("overflow", o_overflow, m_ovf);
    check("tx_dv",    o_Tx_DV,    m_dv);
    check("tx_byte",  o_Tx_Byte,  m_byte);
  endtask

  // Transmitter: goes busy on a strobe, pulses done tx_lat cycles later.
  task automatic tx_model();
    i_Tx_Done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        i_Tx_Done = 1'b1;
        tx_act    = 1'b0;
      end
    end
    if (o_Tx_DV) begin
      tx_act = 1'b1;
      tx_cnt = tx_lat;
      seen.push_back(o_Tx_Byte);
    end
    i_Tx_Active = tx_act || hold_busy;
  endtask

  task automatic step();
    @(posedge clk_tb);
    model_edge();
    #1;
    compare_all();
    if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
    tx_model();
  endtask

  task automatic push_step(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    step();
    i_Rx_DV   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((m_q.size() > 0 || m_inflight || m_block > 0 || tx_act) && n < 5000) begin
      step();
      n++;
    end
    check(name, (n < 5000), 1'b1);
  endtask

  task automatic check_seen(input string name);
    check({name, "_len"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
      check({name, "_byte"}, seen[i], exp_q[i]);
  endtask

  initial begin
    reset = 1'b0; i_Rx_DV = 1'b0; i_Rx_Byte = 8'h00; i_Tx_Active = 1'b0;
    i_Tx_Done = 1'b0; i_ovf_clr = 1'b0;
    tx_act = 1'b0; tx_cnt = 0; tx_lat = 20; hold_busy = 1'b0; max_cnt = 0;
    model_reset();

    // Reset state
    step();
    step();
    check("rst_count", o_count, 5'd0);
    check("rst_empty", o_empty, 1'b1);
    check("rst_full", o_full, 1'b0);
    check("rst_ovf", o_overflow, 1'b0);
    check("rst_dv", o_Tx_DV, 1'b0);
    check("rst_byte", o_Tx_Byte, 8'h00);
    #3 reset = 1'b1;

    // Single echo: strobe two edges after the push
    seen.delete();
    push_step(8'h55);
    check("echo_cnt1", o_count, 5'd1);
    check("echo_dv0", o_Tx_DV, 1'b0);
    step();
    check("echo_dv1", o_Tx_DV, 1'b1);
    check("echo_byte", o_Tx_Byte, 8'h55);
    check("echo_cnt0", o_count, 5'd0);
    drain("echo_drain");
    exp_q = '{8'h55};
    check_seen("echo");

    // Burst of three with a slow transmitter
    seen.delete(); max_cnt = 0; tx_lat = 100;
    push_step(8'h11); push_step(8'h22); push_step(8'h33);
    drain("burst_drain");
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_seen("burst");
    check("burst_peak", max_cnt, 2);

    // Overflow with transmitter held busy, then push at full on the issue edge
    seen.delete(); tx_lat = 5; hold_busy = 1'b1; i_Tx_Active = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_step(8'(i));
      if (i == 15) begin
        check("ovf_full", o_full, 1'b1);
        check("ovf_none", o_overflow, 1'b0);
      end
    end
    check("ovf_set", o_overflow, 1'b1);
    check("ovf_cnt", o_count, 5'd16);
    hold_busy = 1'b0; i_Tx_Active = tx_act;
    push_step(8'hAA);
    check("pf_dv", o_Tx_DV, 1'b1);
    check("pf_byte", o_Tx_Byte, 8'h00);
    check("pf_cnt", o_count, 5'd16);
    drain("ovf_drain");
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hAA);
    check_seen("ovf");
    check("ovf_sticky", o_overflow, 1'b1);
    i_ovf_clr = 1'b1; step(); i_ovf_clr = 1'b0;
    check("ovf_clr", o_overflow, 1'b0);

    // Pointer wrap: 40 incrementing bytes, spaced so none are dropped
    seen.delete(); exp_q.delete(); tx_lat = 2;
    for (int i = 0; i < 40; i++) begin
      push_step(8'(8'h80 + i));
      exp_q.push_back(8'(8'h80 + i));
      repeat ($urandom_range(4, 8)) step();
    end
    drain("wrap_drain");
    check_seen("wrap");
    check("wrap_empty", o_empty, 1'b1);
    check("wrap_ovf", o_overflow, 1'b0);

    // Reset in the middle of a transmission with bytes queued
    seen.delete(); tx_lat = 50;
    push_step(8'h5A);
    step();
    push_step(8'h01); push_step(8'h02); push_step(8'h03);
    exp_q = '{8'h5A};
    check_seen("mid_first");
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("mrst_count", o_count, 5'd0);
    check("mrst_empty", o_empty, 1'b1);
    check("mrst_full", o_full, 1'b0);
    check("mrst_ovf", o_overflow, 1'b0);
    check("mrst_dv", o_Tx_DV, 1'b0);
    check("mrst_byte", o_Tx_Byte, 8'h00);
    step();
    #2 reset = 1'b1;
    seen.delete();
    repeat (60) step();
    check("mrst_nostrobe", seen.size(), 0);
    tx_lat = 10;
    push_step(8'h66);
    drain("mrst_drain");
    exp_q = '{8'h66};
    check_seen("mrst_echo");

    // Randomized traffic checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      i_Rx_DV   = ($urandom_range(0, 99) < 45);
      i_Rx_Byte = 8'($urandom_range(0, 255));
      i_ovf_clr = ($urandom_range(0, 19) == 0);
      tx_lat    = $urandom_range(1, 30);
      if ($urandom_range(0, 15) == 0) hold_busy = !hold_busy;
      i_Tx_Active = tx_act || hold_busy;
      step();
      i_Rx_DV = 1'b0; i_ovf_clr = 1'b0;
    end
    hold_busy = 1'b0; i_Tx_Active = tx_act;
    drain("rand_drain");
    check("rand_empty", o_empty, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
